axi4_burst_ram: RTL and testbench
=================================

Name: axi4_burst_ram

Overview:
- Parametrised AXI4 slave that terminates INCR bursts into an internal byte-addressable dual-port RAM.
- Write and read channels run independently, each with its own FSM.
- Adds WLAST/RLAST, byte strobes, per-beat range checking and SLVERR reporting.
- Sits behind the interconnect as a scratch/test memory target for DSIM tutorials and bus-master benches.

Parameters:
- ADDR_W, 32, address width of awaddr/araddr.
- DATA_W, 32, data width; must be 32 or 64; STRB_W = DATA_W/8.
- DEPTH, 1024, number of DATA_W words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH*STRB_W.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- awaddr  in  ADDR_W  write burst start byte address.
- awlen  in  8  beats minus one.
- awvalid / awready  in / out  1  write address handshake.
- wdata  in  DATA_W  write data.
- wstrb  in  STRB_W  byte enables.
- wlast  in  1  final write beat marker.
- wvalid / wready  in / out  1  write data handshake.
- bresp  out  2  write response.
- bvalid / bready  out / in  1  write response handshake.
- araddr  in  ADDR_W  read burst start byte address.
- arlen  in  8  beats minus one.
- arvalid / arready  in / out  1  read address handshake.
- rdata  out  DATA_W  read data.
- rresp  out  2  per-beat read response.
- rlast  out  1  final read beat marker.
- rvalid / rready  out / in  1  read data handshake.

Behaviour:
- Reset (resetn low, asynchronous): awready=1, arready=1, wready=0, bvalid=0, bresp=OKAY, rvalid=0, rlast=0, rresp=OKAY, rdata=0. Both FSMs go to IDLE. RAM contents are not reset.
- Reset asserted mid-burst aborts the burst immediately. No further RAM writes occur. No response is issued after release.
- Addresses are word-aligned: the low log2(STRB_W) address bits are ignored. Beat n address = start + n*STRB_W. Only INCR bursts are supported; there are no burst/size ports.
- Range check is per beat. A word is in range when BASE_ADDR <= addr < BASE_ADDR + DEPTH*STRB_W. The check is done on an ADDR_W+1-bit sum so a burst that wraps past 2^ADDR_W is out of range.
- Write FSM, W_IDLE:
  - awready=1.
  - On awvalid&awready: latch address and length, clear beat counter and error flag, go to W_DATA (awready=0, wready=1 next cycle).
- Write FSM, W_DATA:
  - Each wvalid&wready writes the bytes where wstrb=1, only if the beat is in range.
  - An out-of-range beat sets the error flag and writes nothing.
  - wlast asserted with beat count != awlen, or wlast deasserted on beat awlen, sets the error flag.
  - The burst ends on beat awlen regardless of wlast. Then wready=0 and the FSM goes to W_RESP.
- Write FSM, W_RESP:
  - bvalid=1, bresp = SLVERR if the error flag is set, else OKAY.
  - On bready: bvalid=0, go to W_IDLE (awready=1 next cycle).
  - Minimum write turnaround: AW at cycle 0, first wready at cycle 1, bvalid the cycle after the last W handshake.
- Read FSM, R_IDLE:
  - arready=1.
  - On arvalid&arready: latch address and length, go to R_DATA.
- Read FSM, R_DATA:
  - rvalid asserts 1 cycle after the AR handshake (one-cycle synchronous RAM read).
  - rdata/rresp/rlast hold stable while rvalid&!rready.
  - The next beat is presented the cycle after each rvalid&rready. A prefetch register keeps a gapless stream when rready stays high.
  - Out-of-range beat: rdata=0, rresp=SLVERR. Otherwise rresp=OKAY.
  - rlast=1 only on beat arlen.
  - After the last handshake: rvalid=0, go to R_IDLE.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data (read-first).
- awlen=0 / arlen=0: single-beat burst, with wlast/rlast on beat 0.
- awlen=255: 256 beats. Use a 9-bit beat counter so it does not overflow.

Decomposition:
- Package axi4_pkg:
  - resp_t codes: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Enum wr_state_t {W_IDLE, W_DATA, W_RESP}.
  - Enum rd_state_t {R_IDLE, R_DATA}.
  - Function word_index(addr) parametrised by STRB_W.
- Sub-module axi4_dp_ram:
  - Simple dual-port RAM: one write port with byte enables, one registered read port, read-first.
  - Parameters DATA_W and DEPTH.

Test Plan:
1. Reset release, then AW addr 0x10 len 3, 4 W beats 0xA0..0xA3 with wstrb=F and wlast on beat 3 -> bresp=OKAY. Then AR addr 0x10 len 3 -> rdata A0,A1,A2,A3, rlast on the 4th beat only, all rresp=OKAY.
2. Write 0xFFFFFFFF to 0x20, then write 0x12345678 with wstrb=4'b0101 -> read 0x20 returns 0xFF34FF78.
3. DEPTH=1024, DATA_W=32: AW addr 0xFF8 len 3 -> beats 0-1 written, beats 2-3 dropped, bresp=SLVERR. AR same range -> rresp OKAY,OKAY,SLVERR,SLVERR, with rdata=0 on the error beats.
4. AW len 1 with wlast asserted on beat 0 -> burst still runs 2 beats, bresp=SLVERR.
5. Read burst len 7 with rready toggled pseudo-randomly -> 8 beats in order, data stable while stalled, no lost or duplicated beats. A concurrent write burst to another region completes with OKAY.
6. Assert resetn low in the middle of beat 2 of a len-7 write -> all outputs return to reset values asynchronously. No bvalid after release. Words for beats 2-7 remain unwritten.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 response codes, channel FSM state types and the byte-to-word
// address helper used by the burst RAM.
package axi4_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Widest byte address handled by word_index (ADDR_W up to 64, plus a carry bit).
  localparam int AXI_AW = 65;

  function automatic logic [AXI_AW-1:0] word_index(input logic [AXI_AW-1:0] addr,
                                                   input int strb_w);
    case (strb_w)
      8:       return addr >> 3;
      4:       return addr >> 2;
      default: return addr;
    endcase
  endfunction

endpackage

// File: rtl/axi4_dp_ram.sv
// Simple dual-port RAM: one byte-enabled write port and one registered read
// port with an enable; a same-word read and write in one cycle returns old data.
module axi4_dp_ram #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  localparam int STRB_W = DATA_W / 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Output register only loads on i_re, so it holds the word while the reader stalls.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4_burst_ram.sv
// AXI4 slave terminating INCR bursts into a byte-addressable dual-port RAM,
// with independent write and read FSMs and per-beat range checking.
module axi4_burst_ram
  import axi4_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [7:0]            awlen,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [7:0]            arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output wr_state_t             o_dbg_wr_state,
  output rd_state_t             o_dbg_rd_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload holds while valid&!ready.

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] L_BASE     = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] L_LIMIT    = L_BASE + (ADDR_W+1)'(DEPTH * STRB_W);
  localparam logic [ADDR_W:0] L_STEP     = (ADDR_W+1)'(STRB_W);
  localparam logic [ADDR_W:0] L_LSB_MASK = (ADDR_W+1)'(STRB_W - 1);

  // The extra top bit keeps a burst that runs past 2^ADDR_W out of range.
  function automatic logic in_range(input logic [ADDR_W:0] a);
    return (a >= L_BASE) && (a < L_LIMIT);
  endfunction

  function automatic logic [IDX_W-1:0] ram_index(input logic [ADDR_W:0] a);
    return IDX_W'(word_index(AXI_AW'(a), STRB_W));
  endfunction

  // ---------------- write channel ----------------
  wr_state_t       r_wr_state;
  logic [ADDR_W:0] r_w_addr;
  logic [7:0]      r_w_len;
  logic [8:0]      r_w_cnt;
  logic            r_w_err;
  logic            r_awready;
  logic            r_wready;
  logic            r_bvalid;
  resp_t           r_bresp;

  logic [ADDR_W:0] w_aw_addr;
  logic            w_w_fire;
  logic            w_w_inr;
  logic            w_w_last_beat;
  logic            w_w_beat_err;

  assign w_aw_addr     = {1'b0, awaddr} & ~L_LSB_MASK;
  assign w_w_fire      = (r_wr_state == W_DATA) && wvalid && r_wready;
  assign w_w_inr       = in_range(r_w_addr);
  assign w_w_last_beat = (r_w_cnt == {1'b0, r_w_len});
  assign w_w_beat_err  = !w_w_inr || (wlast != w_w_last_beat);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_state <= W_IDLE;
      r_w_addr   <= '0;
      r_w_len    <= '0;
      r_w_cnt    <= '0;
      r_w_err    <= 1'b0;
      r_awready  <= 1'b1;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= OKAY;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (awvalid && r_awready) begin
            r_w_addr   <= w_aw_addr;
            r_w_len    <= awlen;
            r_w_cnt    <= '0;
            r_w_err    <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b1;
            r_wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_fire) begin
            r_w_err <= r_w_err | w_w_beat_err;
            // Beat count, not wlast, ends the burst.
            if (w_w_last_beat) begin
              r_wready   <= 1'b0;
              r_bvalid   <= 1'b1;
              r_bresp    <= (r_w_err || w_w_beat_err) ? SLVERR : OKAY;
              r_wr_state <= W_RESP;
            end else begin
              r_w_cnt  <= r_w_cnt + 9'd1;
              r_w_addr <= r_w_addr + L_STEP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid   <= 1'b0;
            r_bresp    <= OKAY;
            r_awready  <= 1'b1;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  rd_state_t       r_rd_state;
  logic [ADDR_W:0] r_r_next;
  logic [7:0]      r_r_len;
  logic [8:0]      r_r_cnt;
  logic            r_arready;
  logic            r_rvalid;
  logic            r_rlast;
  logic            r_r_oor;
  resp_t           r_rresp;

  logic [ADDR_W:0] w_ar_addr;
  logic [ADDR_W:0] w_rd_addr;
  logic            w_ar_fire;
  logic            w_r_fire;
  logic            w_r_advance;
  logic            w_ram_re;
  logic [DATA_W-1:0] w_ram_q;

  assign w_ar_addr   = {1'b0, araddr} & ~L_LSB_MASK;
  assign w_ar_fire   = (r_rd_state == R_IDLE) && arvalid && r_arready;
  assign w_r_fire    = (r_rd_state == R_DATA) && r_rvalid && rready;
  assign w_r_advance = w_r_fire && !r_rlast;
  // The RAM output register acts as the prefetch stage: it is reloaded with the
  // next beat exactly on a handshake, giving a gapless stream when rready stays high.
  assign w_rd_addr   = (r_rd_state == R_IDLE) ? w_ar_addr : r_r_next;
  assign w_ram_re    = w_ar_fire || w_r_advance;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_state <= R_IDLE;
      r_r_next   <= '0;
      r_r_len    <= '0;
      r_r_cnt    <= '0;
      r_arready  <= 1'b1;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_r_oor    <= 1'b0;
      r_rresp    <= OKAY;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_fire) begin
            r_r_len    <= arlen;
            r_r_cnt    <= '0;
            r_r_next   <= w_ar_addr + L_STEP;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rlast    <= (arlen == 8'd0);
            r_r_oor    <= !in_range(w_ar_addr);
            r_rresp    <= in_range(w_ar_addr) ? OKAY : SLVERR;
            r_rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_fire) begin
            if (r_rlast) begin
              r_rvalid   <= 1'b0;
              r_rlast    <= 1'b0;
              r_r_oor    <= 1'b0;
              r_rresp    <= OKAY;
              r_arready  <= 1'b1;
              r_rd_state <= R_IDLE;
            end else begin
              r_r_cnt  <= r_r_cnt + 9'd1;
              r_r_next <= r_r_next + L_STEP;
              r_rlast  <= ((r_r_cnt + 9'd1) == {1'b0, r_r_len});
              r_r_oor  <= !in_range(r_r_next);
              r_rresp  <= in_range(r_r_next) ? OKAY : SLVERR;
            end
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  axi4_dp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_w_fire && w_w_inr),
    .i_waddr (ram_index(r_w_addr)),
    .i_wdata (wdata),
    .i_wstrb (wstrb),
    .i_re    (w_ram_re),
    .i_raddr (ram_index(w_rd_addr)),
    .o_rdata (w_ram_q)
  );

  assign awready        = r_awready;
  assign wready         = r_wready;
  assign bvalid         = r_bvalid;
  assign bresp          = r_bresp;
  assign arready        = r_arready;
  assign rvalid         = r_rvalid;
  assign rlast          = r_rlast;
  assign rresp          = r_rresp;
  assign rdata          = (r_rvalid && !r_r_oor) ? w_ram_q : '0;
  assign o_dbg_wr_state = r_wr_state;
  assign o_dbg_rd_state = r_rd_state;

endmodule

// File: tb/tb_axi4_burst_ram.sv
// Directed bench for axi4_burst_ram: bursts, strobes, range errors, wlast
// errors, stalled reads with a concurrent write, and mid-burst reset.
module tb_axi4_burst_ram;
  import axi4_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              resetn;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  wr_state_t         dbg_wr;
  rd_state_t         dbg_rd;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_d[$];
  logic [1:0]        got_r[$];
  logic              got_l[$];

  axi4_burst_ram #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(32'h0)
  ) dut (
    .clk(clk), .resetn(resetn),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .o_dbg_wr_state(dbg_wr), .o_dbg_rd_state(dbg_rd)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic aw_send(input logic [31:0] a, input logic [7:0] l, output bit tmo);
    awaddr = a; awlen = l; awvalid = 1'b1; tmo = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (awready) begin tmo = 1'b0; break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] l, output bit tmo);
    araddr = a; arlen = l; arvalid = 1'b1; tmo = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (arready) begin tmo = 1'b0; break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  // Beat i carries d0+i; wlast is driven high only on beat last_at.
  task automatic do_write(input logic [31:0] a, input logic [7:0] l, input logic [31:0] d0,
                          input logic [3:0] strb, input int last_at,
                          output logic [1:0] resp, output bit tmo);
    bit t;
    resp = 2'bxx;
    aw_send(a, l, tmo);
    if (tmo) return;
    for (int i = 0; i <= int'(l); i++) begin
      wdata = d0 + i; wstrb = strb; wlast = (i == last_at); wvalid = 1'b1;
      t = 1'b1;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (wready) begin t = 1'b0; break; end
      end
      if (t) tmo = 1'b1;
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1;
    t = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bvalid) begin t = 1'b0; resp = bresp; break; end
    end
    if (t) tmo = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Collects beats into got_*; counts payload changes seen while stalled.
  task automatic do_read(input logic [31:0] a, input logic [7:0] l, input bit rnd,
                         output int stall_err, output bit tmo);
    int beats;
    bit prev_stall;
    logic [31:0] pd;
    logic [1:0] pr;
    logic pl;
    got_d.delete(); got_r.delete(); got_l.delete();
    stall_err = 0; beats = 0; prev_stall = 1'b0;
    pd = '0; pr = '0; pl = 1'b0;
    ar_send(a, l, tmo);
    if (tmo) return;
    for (int c = 0; c < 2000 && beats <= int'(l); c++) begin
      rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rvalid) begin
        if (prev_stall && (rdata !== pd || rresp !== pr || rlast !== pl)) stall_err++;
        if (rready) begin
          got_d.push_back(rdata); got_r.push_back(rresp); got_l.push_back(rlast);
          beats++; prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1; pd = rdata; pr = rresp; pl = rlast;
        end
      end else if (prev_stall) begin
        stall_err++; prev_stall = 1'b0;
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    if (beats <= int'(l)) tmo = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    awaddr = '0; awlen = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
    wvalid = 1'b0; bready = 1'b0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b exp 110000", {awready, arready, wready, bvalid, rvalid, rlast}); end
    tests_run++; if ({bresp, rresp} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_resp: got %b exp 0000", {bresp, rresp}); end
    tests_run++; if (rdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_rdata: got %h exp 00000000", rdata); end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    tests_run++; if (dbg_wr !== W_IDLE || dbg_rd !== R_IDLE) begin
      tests_failed++; $display("FAIL reset_state: got %0d/%0d exp 0/0", dbg_wr, dbg_rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_burst();
    logic [1:0] resp; bit tmo; int se;
    do_write(32'h10, 8'd3, 32'hA0, 4'hF, 3, resp, tmo);
    tests_run++; if (tmo !== 1'b0 || resp !== OKAY) begin
      tests_failed++; $display("FAIL basic_bresp: got %b tmo %0d exp 00", resp, tmo); end
    do_read(32'h10, 8'd3, 1'b0, se, tmo);
    tests_run++; if (tmo !== 1'b0 || got_d.size() != 4) begin
      tests_failed++; $display("FAIL basic_beats: got %0d tmo %0d exp 4", got_d.size(), tmo); end
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
    for (int i = 0; i < got_d.size() && i < 4; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      tests_run++; if (got_d[i] !== e) begin
        tests_failed++; $display("FAIL basic_rdata[%0d]: got %h exp %h", i, got_d[i], e); end
      tests_run++; if (got_r[i] !== OKAY || got_l[i] !== (i == 3)) begin
        tests_failed++; $display("FAIL basic_rresp_rlast[%0d]: got %b/%b exp 00/%b", i, got_r[i], got_l[i], i == 3); end
    end
    exp_q.delete();
    @(negedge clk);
    tests_run++; if (rvalid !== 1'b0) begin
      tests_failed++; $display("FAIL basic_rvalid_after: got %b exp 0", rvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_strobe();
    logic [1:0] r1, r2; bit t1, t2, tmo; int se;
    do_write(32'h20, 8'd0, 32'hFFFF_FFFF, 4'hF, 0, r1, t1);
    do_write(32'h20, 8'd0, 32'h1234_5678, 4'b0101, 0, r2, t2);
    tests_run++; if (t1 || t2 || r1 !== OKAY || r2 !== OKAY) begin
      tests_failed++; $display("FAIL strobe_bresp: got %b/%b exp 00/00", r1, r2); end
    do_read(32'h20, 8'd0, 1'b0, se, tmo);
    exp_q.push_back(32'hFF34_FF78);
    tests_run++; if (tmo || got_d.size() != 1 || got_d[0] !== exp_q[0] || got_l[0] !== 1'b1) begin
      tests_failed++; $display("FAIL strobe_rdata: got %h exp %h", (got_d.size() > 0) ? got_d[0] : 32'hx, exp_q[0]); end
    exp_q.delete();
  endtask

  task automatic test_range();
    logic [1:0] resp; bit tmo; int se;
    logic [31:0] ed [4];
    logic [1:0]  er [4];
    ed = '{32'hB0, 32'hB1, 32'h0, 32'h0};
    er = '{OKAY, OKAY, SLVERR, SLVERR};
    do_write(32'h0, 8'd1, 32'h11, 4'hF, 1, resp, tmo);
    do_write(32'hFF8, 8'd3, 32'hB0, 4'hF, 3, resp, tmo);
    tests_run++; if (tmo || resp !== SLVERR) begin
      tests_failed++; $display("FAIL range_bresp: got %b exp 10", resp); end
    do_read(32'hFF8, 8'd3, 1'b0, se, tmo);
    tests_run++; if (tmo || got_d.size() != 4) begin
      tests_failed++; $display("FAIL range_beats: got %0d exp 4", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 4; i++) begin
      tests_run++; if (got_d[i] !== ed[i] || got_r[i] !== er[i]) begin
        tests_failed++; $display("FAIL range_beat[%0d]: got %h/%b exp %h/%b", i, got_d[i], got_r[i], ed[i], er[i]); end
    end
    do_read(32'h0, 8'd1, 1'b0, se, tmo);
    tests_run++; if (tmo || got_d.size() != 2 || got_d[0] !== 32'h11 || got_d[1] !== 32'h12) begin
      tests_failed++; $display("FAIL range_no_alias: got %h %h exp 00000011 00000012",
                               (got_d.size() > 0) ? got_d[0] : 32'hx, (got_d.size() > 1) ? got_d[1] : 32'hx); end
  endtask

  task automatic test_wlast_error();
    logic [1:0] resp; bit tmo; int se;
    do_write(32'h40, 8'd1, 32'hC0, 4'hF, 0, resp, tmo);
    tests_run++; if (tmo || resp !== SLVERR) begin
      tests_failed++; $display("FAIL wlast_early: got %b tmo %0d exp 10", resp, tmo); end
    do_write(32'h48, 8'd1, 32'hC8, 4'hF, -1, resp, tmo);
    tests_run++; if (tmo || resp !== SLVERR) begin
      tests_failed++; $display("FAIL wlast_missing: got %b tmo %0d exp 10", resp, tmo); end
    do_read(32'h40, 8'd1, 1'b0, se, tmo);
    tests_run++; if (tmo || got_d.size() != 2 || got_d[0] !== 32'hC0 || got_d[1] !== 32'hC1) begin
      tests_failed++; $display("FAIL wlast_data: got %h %h exp 000000c0 000000c1",
                               (got_d.size() > 0) ? got_d[0] : 32'hx, (got_d.size() > 1) ? got_d[1] : 32'hx); end
  endtask

  task automatic test_stall_concurrent();
    logic [1:0] resp; bit tmo, rtmo, wtmo; int se;
    do_write(32'h200, 8'd7, 32'hD0, 4'hF, 7, resp, tmo);
    fork
      do_read(32'h200, 8'd7, 1'b1, se, rtmo);
      do_write(32'h300, 8'd3, 32'hE0, 4'hF, 3, resp, wtmo);
    join
    tests_run++; if (rtmo || got_d.size() != 8) begin
      tests_failed++; $display("FAIL stall_beats: got %0d exp 8", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      tests_run++; if (got_d[i] !== 32'hD0 + i || got_r[i] !== OKAY || got_l[i] !== (i == 7)) begin
        tests_failed++; $display("FAIL stall_beat[%0d]: got %h/%b/%b exp %h/00/%b", i, got_d[i], got_r[i], got_l[i], 32'hD0 + i, i == 7); end
    end
    tests_run++; if (se != 0) begin
      tests_failed++; $display("FAIL stall_stable: got %0d changes exp 0", se); end
    tests_run++; if (wtmo || resp !== OKAY) begin
      tests_failed++; $display("FAIL concurrent_bresp: got %b exp 00", resp); end
    do_read(32'h300, 8'd3, 1'b0, se, tmo);
    tests_run++; if (tmo || got_d.size() != 4 || got_d[0] !== 32'hE0 || got_d[3] !== 32'hE3) begin
      tests_failed++; $display("FAIL concurrent_data: got %h..%h exp 000000e0..000000e3",
                               (got_d.size() > 0) ? got_d[0] : 32'hx, (got_d.size() > 3) ? got_d[3] : 32'hx); end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] resp; bit tmo; int se; int seen_b;
    do_write(32'h100, 8'd7, 32'h5A0, 4'hF, 7, resp, tmo);
    aw_send(32'h100, 8'd7, tmo);
    for (int i = 0; i < 2; i++) begin
      wdata = 32'hBB0 + i; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (wready) break;
      end
      @(posedge clk); #1;
    end
    wdata = 32'hBB2;
    @(negedge clk); #1;
    resetn = 1'b0;
    #1;
    tests_run++; if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
      tests_failed++; $display("FAIL midreset_ctrl: got %b exp 110000", {awready, arready, wready, bvalid, rvalid, rlast}); end
    tests_run++; if ({bresp, rresp} !== 4'b0000 || rdata !== 32'h0 || dbg_wr !== W_IDLE) begin
      tests_failed++; $display("FAIL midreset_out: got %b/%h/%0d exp 0000/00000000/0", {bresp, rresp}, rdata, dbg_wr); end
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1; resetn = 1'b1;
    bready = 1'b1;
    seen_b = 0;
    repeat (10) begin
      @(negedge clk);
      if (bvalid) seen_b++;
    end
    bready = 1'b0;
    tests_run++; if (seen_b != 0) begin
      tests_failed++; $display("FAIL midreset_no_b: got %0d bvalid cycles exp 0", seen_b); end
    @(posedge clk); #1;
    do_read(32'h100, 8'd7, 1'b0, se, tmo);
    tests_run++; if (tmo || got_d.size() != 8) begin
      tests_failed++; $display("FAIL midreset_beats: got %0d exp 8", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      logic [31:0] e;
      e = (i < 2) ? 32'hBB0 + i : 32'h5A0 + i;
      tests_run++; if (got_d[i] !== e) begin
        tests_failed++; $display("FAIL midreset_word[%0d]: got %h exp %h", i, got_d[i], e); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic_burst();
    test_strobe();
    test_range();
    test_wlast_error();
    test_stall_concurrent();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
